serial_addsub16: RTL
====================

Name: serial_addsub16

Overview:
- Nibble-serial 16-bit add/subtract sequencer. It sits directly upstream of the 4-bit carry-lookahead adder slice and drives it with one operand nibble per cycle.
- The slice's carry-out is registered and fed back as the carry-in of the next nibble.
- Operands are accepted through a valid/ready handshake, and a 16-bit result plus flags is returned through a second valid/ready handshake.
- Trades one 16-bit adder for a single reused 4-bit CLA slice plus a few registers.

Parameters:
- NIBBLES, 4, number of 4-bit slices processed; operand width W = 4*NIBBLES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op_sub are valid.
- in_ready  output  1  block accepts operands (high only in IDLE).
- a  input  W  operand A (two's complement / unsigned).
- b  input  W  operand B.
- op_sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer takes the result.
- result  output  W  sum/difference.
- carry  output  1  final carry-out. For subtraction, 1 = no borrow (A >= B unsigned).
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.
- busy  output  1  state is RUN or DONE.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n); all registers clear immediately on assertion.
- Reset values:
  - State = IDLE.
  - result = 0; carry, overflow, zero = 0.
  - out_valid = 0, busy = 0.
  - in_ready = 1, since it is decoded from IDLE.
  - Slice counter = 0; carry register = 0.
- States:
  - IDLE: in_ready = 1. On in_valid at a rising edge:
    - latch A;
    - latch B' = op_sub ? ~b : b;
    - latch carry register = op_sub;
    - clear counter;
    - go to RUN.
  - RUN: each cycle, slice k = counter feeds the adder with A[4k+3:4k], B'[4k+3:4k] and the carry register. At the edge:
    - store the slice sum into result[4k+3:4k];
    - carry register <= slice carry-out;
    - counter++.
    - When counter == NIBBLES-1, go to DONE.
    - in_valid is ignored.
  - DONE: out_valid = 1; result and all flags are held stable. On out_valid && out_ready at an edge, go to IDLE.
- Latency: the accept edge is E0. RUN covers edges E1..E_NIBBLES, and out_valid is high from E_NIBBLES. This gives 4 cycles at the default; throughput is one operation per NIBBLES+2 cycles minimum.
- in_ready is low in RUN and DONE. No accept occurs in the same cycle as the result handshake; in_ready rises the cycle after the handshake.
- Flags are registered at the transition into DONE:
  - carry = final slice carry-out;
  - overflow = (A[W-1] == B'[W-1]) && (result[W-1] != A[W-1]);
  - zero = ~|result.
- Arithmetic is modulo 2^W. Carry is not an input; op_sub alone supplies the initial carry.
- result, when not in DONE, is don't-care to consumers but must not glitch in DONE.
- out_ready held low: stay in DONE indefinitely with outputs frozen.
- in_valid held high across operations: exactly one accept per IDLE visit.
- rst_n asserted in any state, including mid-RUN: immediate return to reset values. The partial result is discarded and no out_valid pulse occurs.
- rst_n released: the first accept is possible at the first rising edge with rst_n high.

Decomposition:
- Shared package:
  - state encoding localparams ST_IDLE, ST_RUN, ST_DONE (2-bit);
  - OP_ADD = 0, OP_SUB = 1;
  - NIBBLE_W = 4.
- One sub-module is natural: cla_slice4, a combinational 4-bit CLA adder (a, b, c_in -> s, c_out), instantiated once.
- FSM, counter, operand/result registers and flags stay in serial_addsub16.

Test Plan:
- ADD 0x1234 + 0x0FCD
  - -> result 0x2201, carry 0, overflow 0, zero 0.
  - out_valid exactly 4 cycles after the accept edge.
  - in_ready low for the whole operation.
- SUB 0x5000 - 0x5000 -> result 0x0000, carry 1, zero 1, overflow 0.
- SUB 0x0003 - 0x0005 -> 0xFFFE, carry 0, overflow 0.
- ADD 0x7FFF + 0x0001 -> 0x8000, overflow 1, carry 0.
- ADD 0xFFFF + 0x0001 -> 0x0000, carry 1, zero 1, overflow 0.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after out_valid, with in_valid = 1 and new operands 0xAAAA/0x5555 on a and b.
  - -> result and flags unchanged, in_ready 0, no second accept.
  - After the handshake, in_ready = 1 on the next cycle, then 0xAAAA + 0x5555 -> 0xFFFF.
- Reset mid-RUN:
  - Assert rst_n = 0 asynchronously, mid-cycle, 2 cycles after accepting 0x1111 + 0x2222.
  - -> outputs and state cleared at once: busy 0, in_ready 1, out_valid 0.
  - After release, a fresh 0x0001 + 0x0001 gives 0x0002 with no leftover carry.

Source files
------------

// File: rtl/serial_addsub16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub16_pkg
// Brief    : Shared constants and types for the nibble-serial add/subtract
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package serial_addsub16_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Status flags captured when the last slice completes
  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } flags_t;

endpackage : serial_addsub16_pkg
`default_nettype wire

// File: rtl/serial_addsub16_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub16_if
// Brief    : Operand and result handshake bundle of serial_addsub16.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_addsub16_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         busy;

  // Producer of operands and consumer of results
  modport master (
    output in_valid, a, b, op_sub, out_ready,
    input  in_ready, out_valid, result, carry, overflow, zero, busy
  );

  // The sequencer itself
  modport slave (
    input  in_valid, a, b, op_sub, out_ready,
    output in_ready, out_valid, result, carry, overflow, zero, busy
  );

endinterface : serial_addsub16_if
`default_nettype wire

// File: rtl/serial_addsub16_cla_slice4.sv
`default_nettype none
// ============================================================================
// Module   : cla_slice4
// Brief    : Combinational 4-bit carry-lookahead adder slice.
// Revision : 1.0 - initial release
// ============================================================================
module cla_slice4 (
  input  wire logic [3:0] i_a,
  input  wire logic [3:0] i_b,
  input  wire logic       i_c,
  output logic      [3:0] o_s,
  output logic            o_c
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  // Generate/propagate terms and flattened lookahead carries
  always_comb begin
    w_p    = i_a ^ i_b;
    w_g    = i_a & i_b;
    w_c[0] = i_c;
    w_c[1] = w_g[0] | (w_p[0] & i_c);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & i_c);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);
    o_s    = w_p ^ w_c[3:0];
    o_c    = w_c[4];
  end

endmodule : cla_slice4
`default_nettype wire

// File: rtl/serial_addsub16.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub16
// Brief    : Nibble-serial add/subtract sequencer reusing one 4-bit CLA slice,
//            one nibble per cycle, with registered carry feedback.
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub16
  import serial_addsub16_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input wire logic         clk,
  input wire logic         rst_n,
  serial_addsub16_if.slave bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NIBBLES - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;      // already inverted for subtraction
  logic             r_c;
  logic [W-1:0]     r_result;
  flags_t           r_flags;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;
  logic [W-1:0]        w_result_next;

  // Select the active nibble and merge the slice sum into the running result
  always_comb begin
    w_a_nib       = r_a[int'(r_cnt) * NIBBLE_W +: NIBBLE_W];
    w_b_nib       = r_b[int'(r_cnt) * NIBBLE_W +: NIBBLE_W];
    w_result_next = r_result;
    w_result_next[int'(r_cnt) * NIBBLE_W +: NIBBLE_W] = w_sum;
  end

  cla_slice4 u_slice (
    .i_a (w_a_nib),
    .i_b (w_b_nib),
    .i_c (r_c),
    .o_s (w_sum),
    .o_c (w_cout)
  );

  // Sequencer: accept operands, walk the slices, hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
            r_c     <= bus.op_sub;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_result <= w_result_next;
          r_c      <= w_cout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            // Flags are frozen together with the final nibble
            r_flags.carry    <= w_cout;
            r_flags.overflow <= (r_a[W-1] == r_b[W-1]) &&
                                (w_result_next[W-1] != r_a[W-1]);
            r_flags.zero     <= ~|w_result_next;
            r_state          <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.result    = r_result;
  assign bus.carry     = r_flags.carry;
  assign bus.overflow  = r_flags.overflow;
  assign bus.zero      = r_flags.zero;

endmodule : serial_addsub16
`default_nettype wire
